// File: rtl/c7bcsr_acc.sv
// CSR access sequencer: runs read-before-write sequences on the CSR register file port.
// Optional privilege check enabled by defining C7BCSR_ACC_PLV_CHECK_EN.
`ifndef LCSR_BIT
`define LCSR_BIT 14
`endif

module c7bcsr_acc #(
    parameter int TAG_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [`LCSR_BIT-1:0] req_addr,
    input  logic [31:0]          req_wdata,
    input  logic [31:0]          req_mask,
    input  logic [TAG_W-1:0]     req_tag,
    input  logic [1:0]           crmd_plv,
    input  logic                 flush,
    output logic [`LCSR_BIT-1:0] csr_raddr,
    input  logic [31:0]          csr_rdata,
    output logic [`LCSR_BIT-1:0] csr_waddr,
    output logic [31:0]          csr_wdata,
    output logic [31:0]          csr_mask,
    output logic                 csr_wen,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_data,
    output logic [TAG_W-1:0]     resp_tag,
    output logic                 resp_except,
    output logic [5:0]           resp_ecode
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_RSV = 2'b11;
    localparam logic [5:0] ECODE_INE = 6'h0D;
    localparam logic [5:0] ECODE_IPE = 6'h0E;

    state_t               state, state_nxt;
    logic [1:0]           op_q;
    logic [`LCSR_BIT-1:0] addr_q;
    logic [31:0]          wdata_q;
    logic [31:0]          mask_q;
    logic [TAG_W-1:0]     tag_q;
    logic [31:0]          data_q;
    logic                 except_q;
    logic [5:0]           ecode_q;

    logic accept;
    logic illegal_op;
    logic plv_fault;

`ifdef C7BCSR_ACC_PLV_CHECK_EN
    assign plv_fault = (crmd_plv != 2'd0);
`else
    logic unused_plv;
    assign unused_plv = ^crmd_plv;
    assign plv_fault  = 1'b0;
`endif

    assign req_ready  = (state == IDLE) & ~flush & ~rst;
    assign accept     = req_valid & req_ready;
    assign illegal_op = (req_op == OP_RSV);

    // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (accept) state_nxt = (illegal_op | plv_fault) ? RESP : READ;
            READ:  state_nxt = flush ? IDLE : ((op_q == OP_RD) ? RESP : WRITE);
            WRITE: state_nxt = flush ? IDLE : RESP;
            RESP:  if (flush | resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= '0;
            mask_q   <= '0;
            tag_q    <= '0;
            data_q   <= '0;
            except_q <= 1'b0;
            ecode_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q     <= req_op;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                mask_q   <= req_mask;
                tag_q    <= req_tag;
                data_q   <= '0;
                except_q <= illegal_op | plv_fault;
                ecode_q  <= illegal_op ? ECODE_INE : (plv_fault ? ECODE_IPE : 6'h00);
            end else if (state == READ && !flush) begin
                data_q <= csr_rdata;
            end
        end
    end

    // Write port is idle outside WRITE; a flush or reset in WRITE suppresses the strobe.
    assign csr_raddr = (state != IDLE) ? addr_q : '0;
    assign csr_wen   = (state == WRITE) & ~flush & ~rst;
    assign csr_waddr = (state == WRITE) ? addr_q : '0;
    assign csr_wdata = (state == WRITE) ? wdata_q : '0;
    assign csr_mask  = (state != WRITE) ? 32'h0 : ((op_q == OP_WR) ? 32'hFFFF_FFFF : mask_q);

    assign resp_valid  = (state == RESP);
    assign resp_data   = data_q;
    assign resp_tag    = tag_q;
    assign resp_except = except_q;
    assign resp_ecode  = ecode_q;

endmodule

// File: tb/tb_c7bcsr_acc.sv
// Self-checking bench for c7bcsr_acc: directed plan items plus random transactions
// checked against a transaction-level CSR model.
`ifndef LCSR_BIT
`define LCSR_BIT 14
`endif

module tb_c7bcsr_acc;
    localparam int TAG_W = 5;
    localparam int DEPTH = 1 << `LCSR_BIT;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 req_valid;
    logic                 req_ready;
    logic [1:0]           req_op;
    logic [`LCSR_BIT-1:0] req_addr;
    logic [31:0]          req_wdata;
    logic [31:0]          req_mask;
    logic [TAG_W-1:0]     req_tag;
    logic [1:0]           crmd_plv;
    logic                 flush;
    logic [`LCSR_BIT-1:0] csr_raddr;
    logic [31:0]          csr_rdata;
    logic [`LCSR_BIT-1:0] csr_waddr;
    logic [31:0]          csr_wdata;
    logic [31:0]          csr_mask;
    logic                 csr_wen;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [31:0]          resp_data;
    logic [TAG_W-1:0]     resp_tag;
    logic                 resp_except;
    logic [5:0]           resp_ecode;

    int checks   = 0;
    int failures = 0;

    // Register file seen by the DUT, and the reference model's view of it.
    logic [31:0] rf      [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    c7bcsr_acc #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
        .req_tag(req_tag), .crmd_plv(crmd_plv), .flush(flush),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_waddr(csr_waddr),
        .csr_wdata(csr_wdata), .csr_mask(csr_mask), .csr_wen(csr_wen),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_tag(resp_tag), .resp_except(resp_except), .resp_ecode(resp_ecode)
    );

    always #5 clk = ~clk;

    assign csr_rdata = rf[csr_raddr];

    always @(posedge clk) begin
        if (csr_wen) rf[csr_waddr] <= (rf[csr_waddr] & ~csr_mask) | (csr_wdata & csr_mask);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One complete transaction; hold = cycles resp_ready stays low once resp_valid is seen.
    task automatic do_txn(input logic [1:0] op, input logic [`LCSR_BIT-1:0] addr,
                          input logic [31:0] wdata, input logic [31:0] mask,
                          input logic [TAG_W-1:0] tag, input logic [1:0] plv, input int hold);
        logic        legal, viol, exec;
        logic [31:0] exp_data, exp_mask;
        logic [5:0]  exp_ecode;
        int          exp_resp, exp_wens, c, wens;
        legal = (op != 2'b11);
`ifdef C7BCSR_ACC_PLV_CHECK_EN
        viol = (plv != 2'd0);
`else
        viol = 1'b0;
`endif
        exec      = legal && !viol;
        exp_data  = exec ? ref_mem[addr] : 32'h0;
        exp_ecode = !legal ? 6'h0D : (viol ? 6'h0E : 6'h00);
        exp_mask  = (op == 2'b01) ? 32'hFFFF_FFFF : mask;
        exp_wens  = (exec && op != 2'b00) ? 1 : 0;
        exp_resp  = !exec ? 1 : ((op == 2'b00) ? 2 : 3);

        @(negedge clk);
        check("req_ready_idle", {31'b0, req_ready}, 32'h1);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        req_mask = mask; req_tag = tag; crmd_plv = plv;
        @(negedge clk);
        req_valid = 1'b0;
        c = 1; wens = 0;
        if (exec) check("raddr_read", {18'b0, csr_raddr}, {18'b0, addr});
        while (!resp_valid && c < 8) begin
            if (csr_wen) begin
                wens++;
                check("wen_cycle", c, 2);
                check("waddr", {18'b0, csr_waddr}, {18'b0, addr});
                check("wdata", csr_wdata, wdata);
                check("wmask", csr_mask, exp_mask);
            end
            @(negedge clk);
            c++;
        end
        check("resp_cycle", c, exp_resp);
        check("wen_count", wens, exp_wens);
        for (int i = 0; i <= hold; i++) begin
            check("resp_valid", {31'b0, resp_valid}, 32'h1);
            check("resp_data", resp_data, exp_data);
            check("resp_tag", {27'b0, resp_tag}, {27'b0, tag});
            check("resp_except", {31'b0, resp_except}, {31'b0, !exec});
            check("resp_ecode", {26'b0, resp_ecode}, {26'b0, exp_ecode});
            check("wen_in_resp", {31'b0, csr_wen}, 32'h0);
            check("req_ready_busy", {31'b0, req_ready}, 32'h0);
            if (i < hold) @(negedge clk);
            else resp_ready = 1'b1;
        end
        @(negedge clk);
        resp_ready = 1'b0;
        check("resp_dropped", {31'b0, resp_valid}, 32'h0);
        check("req_ready_after", {31'b0, req_ready}, 32'h1);
        if (exec && op == 2'b01) ref_mem[addr] = wdata;
        if (exec && op == 2'b10) ref_mem[addr] = (ref_mem[addr] & ~mask) | (wdata & mask);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'h0);
        check({tag, "_wen"}, {31'b0, csr_wen}, 32'h0);
        check({tag, "_raddr"}, {18'b0, csr_raddr}, 32'h0);
        check({tag, "_waddr"}, {18'b0, csr_waddr}, 32'h0);
        check({tag, "_wdata"}, csr_wdata, 32'h0);
        check({tag, "_mask"}, csr_mask, 32'h0);
    endtask

    initial begin
        logic [`LCSR_BIT-1:0] addrs [5];
        addrs[0] = 14'h0; addrs[1] = 14'h6; addrs[2] = 14'hC; addrs[3] = 14'h20; addrs[4] = 14'h3FFF;
        for (int i = 0; i < DEPTH; i++) begin
            rf[i] = $urandom;
            ref_mem[i] = rf[i];
        end
        rf[0]  = 32'h4;         ref_mem[0]  = 32'h4;
        rf[12] = 32'h1C00_0000; ref_mem[12] = 32'h1C00_0000;
        rf[6]  = 32'h1234_5678; ref_mem[6]  = 32'h1234_5678;

        rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_wdata = '0;
        req_mask = '0; req_tag = '0; crmd_plv = 2'd0; flush = 1'b0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'h0);
        check_idle_outputs("rst");
        check("rst_resp_data", resp_data, 32'h0);
        check("rst_resp_tag", {27'b0, resp_tag}, 32'h0);
        check("rst_except", {31'b0, resp_except}, 32'h0);
        check("rst_ecode", {26'b0, resp_ecode}, 32'h0);
        rst = 1'b0;
        #1 check("post_rst_ready", {31'b0, req_ready}, 32'h1);

        // csrrd CRMD, csrxchg EENTRY then read back, csrwr with stalled writeback.
        do_txn(2'b00, 14'h0, 32'h0, 32'h0, 5'd3, 2'd0, 0);
        do_txn(2'b10, 14'hC, 32'hFFFF_0000, 32'h00FF_0000, 5'd7, 2'd0, 0);
        do_txn(2'b00, 14'hC, 32'h0, 32'h0, 5'd8, 2'd0, 0);
        check("eentry_value", ref_mem[12], 32'h1CFF_0000);
        do_txn(2'b01, 14'h20, 32'hCAFE_F00D, 32'h0, 5'd9, 2'd0, 5);
        do_txn(2'b11, 14'h6, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 5'd10, 2'd0, 0);
        do_txn(2'b01, 14'h20, 32'h0BAD_0BAD, 32'h0, 5'd11, 2'd3, 0);
        do_txn(2'b01, 14'h20, 32'h600D_600D, 32'h0, 5'd12, 2'd0, 0);

        // Flush during WRITE of a csrwr to ERA.
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b01; req_addr = 14'h6; req_wdata = 32'hFFFF_FFFF; req_tag = 5'd1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        #1 check("flush_wen", {31'b0, csr_wen}, 32'h0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check_idle_outputs("flush");
        check("flush_ready", {31'b0, req_ready}, 32'h1);
        do_txn(2'b00, 14'h6, 32'h0, 32'h0, 5'd2, 2'd0, 0);
        check("era_unchanged", rf[6], 32'h1234_5678);

        // Flush coinciding with a request in IDLE blocks the accept.
        @(negedge clk);
        req_valid = 1'b1; flush = 1'b1; req_op = 2'b00; req_addr = 14'hC;
        #1 check("flush_idle_ready", {31'b0, req_ready}, 32'h0);
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        #1 check_idle_outputs("flush_idle");

        // Reset during WRITE: no write, no response.
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b01; req_addr = 14'h6; req_wdata = 32'h0; req_tag = 5'd4;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1 check("rst_mid_wen", {31'b0, csr_wen}, 32'h0);
        @(negedge clk);
        check_idle_outputs("rst_mid");
        check("rst_mid_ready", {31'b0, req_ready}, 32'h0);
        rst = 1'b0;
        check("era_after_rst", rf[6], 32'h1234_5678);

        for (int n = 0; n < 60; n++) begin
            do_txn(2'($urandom_range(0, 3)), addrs[$urandom_range(0, 4)], $urandom, $urandom,
                   5'($urandom), 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 5; i++) check("final_rf", rf[addrs[i]], ref_mem[addrs[i]]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
